// File: rtl/pll_pkg.sv
// Shared definitions for the PLL frequency-measurement blocks.
package pll_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_WIN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } fc_state_t;

endpackage

// File: rtl/freq_counter_if.sv
// Control/result bundle of the frequency counter.
interface freq_counter_if #(
  parameter int CNT_W = pll_pkg::DEF_CNT_W,
  parameter int WIN_W = pll_pkg::DEF_WIN_W
) ();
  logic                    enable;
  logic [WIN_W-1:0]        win_len;
  logic [CNT_W-1:0]        target;
  logic [CNT_W-1:0]        count;
  logic signed [CNT_W:0]   error;
  logic                    count_valid;
  logic                    sat;

  modport master (output enable, win_len, target,
                  input  count, error, count_valid, sat);
  modport slave  (input  enable, win_len, target,
                  output count, error, count_valid, sat);
endinterface

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference clock into clk_out and flags each rising
// edge with a single-cycle pulse, SYNC_STAGES+1 cycles after the edge.
module ref_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_out,
  input  logic rst,
  input  logic ref_in,
  output logic ref_rise
);
  // Depth below 2 is not metastability-safe, so it is clamped.
  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  // Synchronizer chain, delayed copy and registered rising-edge pulse.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      ref_rise <= 1'b0;
    end else begin
      sync_q   <= {sync_q[N-2:0], ref_in};
      prev_q   <= sync_q[N-1];
      ref_rise <= sync_q[N-1] & ~prev_q;
    end
  end
endmodule

// File: rtl/freq_counter.sv
// Counts clk_out cycles over a window of win_len reference periods and
// reports the count, its signed deviation from target and a saturation flag.
module freq_counter
  import pll_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_out,
  input  logic           rst,
  input  logic           ref_in,
  freq_counter_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fc_state_t             state;
  logic [CNT_W-1:0]      acc;
  logic [WIN_W-1:0]      periods;
  logic [WIN_W-1:0]      win;
  logic                  ovf;
  logic                  ref_rise;

  logic [CNT_W-1:0]      count_q;
  logic signed [CNT_W:0] error_q;
  logic                  sat_q;
  logic                  valid_q;

  logic                  acc_full;
  logic [CNT_W-1:0]      acc_inc;
  logic [WIN_W:0]        per_inc;
  logic                  win_close;
  logic [WIN_W-1:0]      win_next;

  ref_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_out  (clk_out),
    .rst      (rst),
    .ref_in   (ref_in),
    .ref_rise (ref_rise)
  );

  // Saturating increment, window-close test and sanitised window length.
  always_comb begin
    acc_full  = (acc == CNT_MAX);
    acc_inc   = acc_full ? CNT_MAX : acc + CNT_W'(1);
    per_inc   = {1'b0, periods} + (WIN_W+1)'(1);
    win_close = (per_inc == {1'b0, win});
    win_next  = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
  end

  // Measurement FSM; results are registered and update together at close.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      periods <= '0;
      win     <= WIN_W'(1);
      ovf     <= 1'b0;
      count_q <= '0;
      error_q <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.enable) begin
        // Partial window is dropped; results keep their last values.
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM: begin
            if (ref_rise) begin
              state   <= ST_COUNT;
              acc     <= '0;
              periods <= '0;
              ovf     <= 1'b0;
              win     <= win_next;
            end
          end
          ST_COUNT: begin
            if (!ref_rise || !win_close) begin
              acc <= acc_inc;
              if (acc_full) ovf <= 1'b1;
              if (ref_rise) periods <= per_inc[WIN_W-1:0];
            end else begin
              // Window close: the closing cycle itself belongs to this window.
              count_q <= acc_inc;
              error_q <= {1'b0, acc_inc} - {1'b0, bus.target};
              sat_q   <= ovf | acc_full;
              valid_q <= 1'b1;
              acc     <= '0;
              periods <= '0;
              ovf     <= 1'b0;
              win     <= win_next;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.error       = error_q;
  assign bus.sat         = sat_q;
  assign bus.count_valid = valid_q;
endmodule

// File: tb/tb_freq_counter.sv
// Self-checking bench: a 16-bit and an 8-bit counter see the same stimulus;
// expected windows come from the list of reference period lengths.
module tb_freq_counter;
  typedef int iq_t[$];
  typedef struct {
    logic [31:0] cnt;
    logic [31:0] err;
    logic        sat;
  } ev_t;

  logic        clk_out = 1'b0;
  logic        rst;
  logic        ref_in;
  logic        enable;
  logic [7:0]  win_len;
  logic [15:0] target;

  int n_chk = 0;
  int n_err = 0;
  ev_t q16[$];
  ev_t q8[$];

  always #5 clk_out = ~clk_out;

  freq_counter_if #(.CNT_W(16), .WIN_W(8)) b16 ();
  freq_counter_if #(.CNT_W(8),  .WIN_W(8)) b8 ();

  assign b16.enable  = enable;
  assign b16.win_len = win_len;
  assign b16.target  = target;
  assign b8.enable   = enable;
  assign b8.win_len  = win_len;
  assign b8.target   = target[7:0];

  freq_counter #(.CNT_W(16), .WIN_W(8), .SYNC_STAGES(2)) dut16 (
    .clk_out (clk_out), .rst (rst), .ref_in (ref_in), .bus (b16));
  freq_counter #(.CNT_W(8), .WIN_W(8), .SYNC_STAGES(2)) dut8 (
    .clk_out (clk_out), .rst (rst), .ref_in (ref_in), .bus (b8));

  // Record every result pulse, sampled mid-cycle.
  always @(negedge clk_out) begin
    ev_t e;
    if (b16.count_valid === 1'b1) begin
      e.cnt = 32'(b16.count);
      e.err = 32'(b16.error);
      e.sat = b16.sat;
      q16.push_back(e);
    end
  end

  always @(negedge clk_out) begin
    ev_t e;
    if (b8.count_valid === 1'b1) begin
      e.cnt = 32'(b8.count);
      e.err = 32'(b8.error);
      e.sat = b8.sat;
      q8.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic iq_t mk(input int p, input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(p);
    return q;
  endfunction

  // One reference period per entry; rising edge at the start of each.
  task automatic gen(input iq_t per);
    foreach (per[i]) begin
      ref_in = 1'b1;
      repeat (per[i] / 2) @(negedge clk_out);
      ref_in = 1'b0;
      repeat (per[i] - per[i] / 2) @(negedge clk_out);
    end
  endtask

  task automatic start(input int w, input int tgt);
    enable = 1'b0;
    repeat (3) @(negedge clk_out);
    q16.delete();
    q8.delete();
    win_len = 8'(w);
    target  = 16'(tgt);
    enable  = 1'b1;
    repeat (2) @(negedge clk_out);
  endtask

  // Reference model: first rise arms, every w-th rise after it closes a
  // window whose count is the sum of the enclosed period lengths.
  task automatic check_windows(input string tag, input int w_in, input int tgt, input iq_t per);
    int w, nw, sum, c16, c8;
    repeat (6) @(negedge clk_out);
    w  = (w_in == 0) ? 1 : w_in;
    nw = (per.size() - 1) / w;
    chk($sformatf("%s.n16", tag), q16.size(), nw);
    chk($sformatf("%s.n8", tag), q8.size(), nw);
    for (int j = 0; j < nw; j++) begin
      sum = 0;
      for (int k = j * w; k < (j + 1) * w; k++) sum += per[k];
      c16 = (sum > 65535) ? 65535 : sum;
      c8  = (sum > 255) ? 255 : sum;
      if (j < q16.size()) begin
        chk($sformatf("%s.w%0d.cnt16", tag, j), q16[j].cnt, c16);
        chk($sformatf("%s.w%0d.err16", tag, j), q16[j].err, c16 - tgt);
        chk($sformatf("%s.w%0d.sat16", tag, j), 32'(q16[j].sat), 32'(sum > 65535));
      end
      if (j < q8.size()) begin
        chk($sformatf("%s.w%0d.cnt8", tag, j), q8[j].cnt, c8);
        chk($sformatf("%s.w%0d.err8", tag, j), q8[j].err, c8 - (tgt % 256));
        chk($sformatf("%s.w%0d.sat8", tag, j), 32'(q8[j].sat), 32'(sum > 255));
      end
    end
  endtask

  initial begin
    iq_t p;
    int rw, rt, rn;
    rst = 1'b1; enable = 1'b0; ref_in = 1'b0; win_len = 8'd1; target = '0;
    repeat (3) @(negedge clk_out);
    chk("rst.count", 32'(b16.count), 0);
    chk("rst.error", 32'(b16.error), 0);
    chk("rst.sat", 32'(b16.sat), 0);
    chk("rst.valid", 32'(b16.count_valid), 0);
    chk("rst.count8", 32'(b8.count), 0);
    rst = 1'b0;

    // 10:1, one period per window
    start(1, 10); p = mk(10, 6); gen(p); check_windows("ratio10_w1", 1, 10, p);

    // 10:1, four periods per window, target off by two
    start(4, 42); p = mk(10, 9); gen(p); check_windows("ratio10_w4", 4, 42, p);

    // long periods saturate the 8-bit counter, then a short ratio clears it
    start(1, 255); p = '{300, 300, 300, 100, 100, 100}; gen(p);
    check_windows("sat", 1, 255, p);

    // zero window length behaves as one
    start(0, 16); p = mk(16, 5); gen(p); check_windows("win0", 0, 16, p);

    // disable two periods into a window: no pulse, results hold
    start(4, 42); p = mk(10, 11); gen(p); check_windows("dis_pre", 4, 42, p);
    enable = 1'b0;
    repeat (20) @(negedge clk_out);
    chk("dis.nopulse", q16.size(), 2);
    chk("dis.hold_cnt", 32'(b16.count), 40);
    chk("dis.hold_err", 32'(b16.error), -2);
    chk("dis.hold_cnt8", 32'(b8.count), 40);
    start(4, 42); p = mk(10, 6); gen(p); check_windows("dis_post", 4, 42, p);

    // reset mid-window clears outputs at once; first rise after only arms
    start(1, 10); p = mk(10, 3); gen(p); check_windows("rst_pre", 1, 10, p);
    rst = 1'b1;
    #1;
    chk("rstmid.count", 32'(b16.count), 0);
    chk("rstmid.error", 32'(b16.error), 0);
    chk("rstmid.sat", 32'(b16.sat), 0);
    chk("rstmid.valid", 32'(b16.count_valid), 0);
    chk("rstmid.count8", 32'(b8.count), 0);
    repeat (2) @(negedge clk_out);
    rst = 1'b0;
    q16.delete();
    q8.delete();
    repeat (3) @(negedge clk_out);
    p = mk(10, 4); gen(p); check_windows("rst_post", 1, 10, p);

    // randomized period lengths, window lengths and targets
    for (int r = 0; r < 4; r++) begin
      rw = $urandom_range(0, 3);
      rt = $urandom_range(0, 200);
      rn = $urandom_range(3, 9);
      p.delete();
      for (int i = 0; i < rn; i++) p.push_back($urandom_range(4, 80));
      start(rw, rt); gen(p); check_windows($sformatf("rand%0d", r), rw, rt, p);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
